instr_fetch: RTL and testbench

Instruction fetch unit for the micro-BESM core, sitting directly upstream of the instruction decoder. It fetches 64-bit instruction words from memory through a two-entry prefetch queue and presents them to the decoder one half at a time. It drives the decoder's `word` and `tkk` inputs: `tkk`=0 is the left half and `tkk`=1 the right half. It also handles control-transfer redirects, including a jump into the right half of a word.

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: two-entry prefetch queue feeding the decoder one half-word at a time,
// with single-outstanding memory reads and jump redirects (including entry at a right half).
module instr_fetch #(
    parameter logic [19:0] RESET_ADDR = 20'h00000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        ins_valid,
    output logic [63:0] ins_word,
    output logic        ins_tkk,
    output logic [19:0] ins_pc,
    input  logic        ins_take,
    input  logic        jump,
    input  logic [19:0] jump_addr,
    input  logic        jump_right
);

    typedef struct packed {
        logic [63:0] word;
        logic [19:0] pc;
    } entry_t;

    entry_t      queue [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [19:0] fpc;
    logic [19:0] req_addr;
    logic        pending;
    logic        discard;
    logic        tkk;
    logic        skip_left;

    logic ack_live;
    logic push;
    logic pop;
    logic advance;

    always_comb begin
        ack_live = mem_ack && pending;
        push     = ack_live && !discard && !jump;
        advance  = ins_take && (count != 2'd0) && !jump;
        pop      = advance && tkk;
    end

    // NOTE: synchronous reset lives inside the clocked block; all state updates use <= so every
    // branch sees the pre-edge values of pending/count/fpc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            fpc       <= RESET_ADDR;
            req_addr  <= RESET_ADDR;
            pending   <= 1'b0;
            discard   <= 1'b0;
            tkk       <= 1'b0;
            skip_left <= 1'b0;
        end else if (jump) begin
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            fpc       <= jump_addr;
            tkk       <= 1'b0;
            skip_left <= jump_right;
            if (!pending) begin
                pending  <= 1'b1;
                req_addr <= jump_addr;
            end else if (mem_ack) begin
                // Ack coincides with the jump: its data is simply not pushed.
                pending <= 1'b0;
                discard <= 1'b0;
            end else begin
                discard <= 1'b1;
            end
        end else begin
            if (ack_live) begin
                pending <= 1'b0;
                discard <= 1'b0;
            end else if (!pending && count != 2'd2) begin
                pending  <= 1'b1;
                req_addr <= fpc;
            end
            if (push) begin
                tail <= ~tail;
                fpc  <= fpc + 20'd1;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + 2'(push) - 2'(pop);
            // First word after a right-half jump starts at its right half.
            if (push && count == 2'd0 && skip_left) begin
                tkk       <= 1'b1;
                skip_left <= 1'b0;
            end else if (advance) begin
                tkk <= ~tkk;
            end
        end
    end

    // NOTE: queue storage is not reset; its contents are only visible through ins_valid gating.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= '{word: mem_rdata, pc: fpc};
        end
    end

    always_comb begin
        mem_req   = pending;
        mem_addr  = req_addr;
        ins_valid = (count != 2'd0);
        ins_tkk   = tkk;
        ins_word  = ins_valid ? queue[head].word : 64'd0;
        ins_pc    = ins_valid ? queue[head].pc : 20'd0;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle-exact vector table with the bench acting as memory,
// plus a hand-written jump/ack collision sequence.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        ins_valid;
    logic [63:0] ins_word;
    logic        ins_tkk;
    logic [19:0] ins_pc;
    logic        ins_take;
    logic        jump;
    logic [19:0] jump_addr;
    logic        jump_right;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_ADDR(20'h00100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ins_valid  (ins_valid),
        .ins_word   (ins_word),
        .ins_tkk    (ins_tkk),
        .ins_pc     (ins_pc),
        .ins_take   (ins_take),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .jump_right (jump_right)
    );

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        take;
        logic        jump;
        logic [19:0] jaddr;
        logic        jright;
        logic        e_req;
        logic [19:0] e_addr;
        logic        e_valid;
        logic [19:0] e_pc;
        logic        e_tkk;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory contents: a recognisable word per address.
    function automatic logic [63:0] word_of(input logic [19:0] a);
        if (a == 20'h00100) return 64'hA5A5_0000_5A5A_1111;
        return {24'hC0FFEE, a, a};
    endfunction

    function automatic vec_t mk(input logic r, input logic ack, input logic take, input logic jmp,
                                input logic [19:0] ja, input logic jr, input logic e_req,
                                input logic [19:0] e_addr, input logic e_v, input logic [19:0] e_pc,
                                input logic e_t);
        vec_t v;
        v.rst_n = r;     v.ack = ack;       v.take = take;   v.jump = jmp;
        v.jaddr = ja;    v.jright = jr;     v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_v; v.e_pc = e_pc;     v.e_tkk = e_t;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
    task automatic step(input vec_t v, input int idx);
        rst_n      = v.rst_n;
        mem_ack    = v.ack;
        mem_rdata  = v.ack ? word_of(mem_addr) : 64'd0;
        ins_take   = v.take;
        jump       = v.jump;
        jump_addr  = v.jaddr;
        jump_right = v.jright;
        @(posedge clk);
        @(negedge clk);
        check("mem_req",   idx, 64'(mem_req),   64'(v.e_req));
        check("mem_addr",  idx, 64'(mem_addr),  64'(v.e_addr));
        check("ins_valid", idx, 64'(ins_valid), 64'(v.e_valid));
        check("ins_pc",    idx, 64'(ins_pc),    64'(v.e_pc));
        check("ins_tkk",   idx, 64'(ins_tkk),   64'(v.e_tkk));
        check("ins_word",  idx, ins_word, v.e_valid ? word_of(v.e_pc) : 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0; ins_take = 1'b0;
        jump = 1'b0; jump_addr = 20'd0; jump_right = 1'b0;

        //              rst ack tk jmp jaddr     jr  req addr      v  pc        t
        // Reset fetch with two wait cycles.
        vecs.push_back(mk(0, 0, 0, 0, 20'h0,     0,  0, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(0, 0, 0, 0, 20'h0,     0,  0, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00100, 1, 20'h00100, 0));
        // Refill to two entries; request stops while full.
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00101, 1, 20'h00100, 0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00101, 1, 20'h00100, 0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  0, 20'h00101, 1, 20'h00100, 0));
        // Half sequencing.
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  0, 20'h00101, 1, 20'h00100, 1));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  0, 20'h00101, 1, 20'h00101, 0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00102, 1, 20'h00101, 0));
        // Jump while 0x102 is outstanding: stale ack dropped.
        vecs.push_back(mk(1, 0, 0, 1, 20'h00200, 0,  1, 20'h00102, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00102, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00102, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00200, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00200, 1, 20'h00200, 0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00201, 1, 20'h00200, 0));
        // Jump-right together with a take: jump wins, queue flushed.
        vecs.push_back(mk(1, 0, 1, 1, 20'h00300, 1,  1, 20'h00201, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00201, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00300, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00300, 1, 20'h00300, 1));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00301, 1, 20'h00300, 1));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00301, 1, 20'h00300, 1));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  0, 20'h00301, 1, 20'h00301, 0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00302, 1, 20'h00301, 0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00302, 1, 20'h00301, 0));
        // Jump to the top address while idle; fetch pointer wraps to zero.
        vecs.push_back(mk(1, 0, 0, 1, 20'hFFFFF, 0,  1, 20'hFFFFF, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'hFFFFF, 1, 20'hFFFFF, 0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00000, 1, 20'hFFFFF, 0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00000, 1, 20'hFFFFF, 0));
        // Spurious ack with no request, then drain: the queue must hold exactly two words.
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00000, 1, 20'hFFFFF, 0));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  0, 20'h00000, 1, 20'hFFFFF, 1));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  0, 20'h00000, 1, 20'h00000, 0));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  1, 20'h00001, 1, 20'h00000, 1));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  1, 20'h00001, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 1, 0, 20'h0,     0,  1, 20'h00001, 0, 20'h0,     0));
        // Reset mid-request; the old ack lands on the release edge and is ignored.
        vecs.push_back(mk(0, 0, 0, 0, 20'h0,     0,  0, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  1, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 0, 0, 0, 20'h0,     0,  1, 20'h00100, 0, 20'h0,     0));
        vecs.push_back(mk(1, 1, 0, 0, 20'h0,     0,  0, 20'h00100, 1, 20'h00100, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Jump arriving in the same cycle as an ack: that data is dropped, refetch at target.
        step(mk(1, 0, 0, 0, 20'h0,     0, 1, 20'h00101, 1, 20'h00100, 0), 100);
        step(mk(1, 1, 0, 1, 20'h00400, 0, 0, 20'h00101, 0, 20'h0,     0), 101);
        step(mk(1, 0, 0, 0, 20'h0,     0, 1, 20'h00400, 0, 20'h0,     0), 102);
        step(mk(1, 1, 0, 0, 20'h0,     0, 0, 20'h00400, 1, 20'h00400, 0), 103);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
